// File: rtl/audio_mixer_reg_sequencer.sv
// Register-port sequencer for the six-channel mixer: boot preset loader, host writes and
// a clk_en-paced master-volume fade engine share one registered write port. Optional boot: AUDIO_SEQ_BOOT_EN.
module audio_mixer_reg_sequencer #(
  parameter logic [7:0] PRESET [0:9] = '{8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64,
                                         8'd128, 8'd0, 8'd25, 8'd128}
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       h_req,
  input  logic [3:0] h_addr,
  input  logic [7:0] h_din,
  output logic       h_ack,
  input  logic       f_start,
  input  logic [7:0] f_target,
  input  logic [7:0] f_rate,
  output logic       f_busy,
  output logic       f_done,
  output logic [3:0] c_addr,
  output logic       c_wr,
  output logic [7:0] c_din,
  output logic       boot_busy
);

  typedef enum logic [1:0] {BOOT, IDLE, FADE_CNT, FADE_WR} state_t;

`ifdef AUDIO_SEQ_BOOT_EN
  localparam state_t RST_STATE = BOOT;
  localparam logic   RST_BOOT  = 1'b1;
`else
  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_BOOT  = 1'b0;
`endif

  state_t     state, state_n;
  logic [3:0] boot_idx, boot_idx_n;
  logic [7:0] vol_sh, vol_n;
  logic [7:0] tgt, tgt_n;
  logic [7:0] rate, rate_n;
  logic [7:0] cnt, cnt_n;
  logic       pend, pend_n;
  logic [3:0] c_addr_n;
  logic [7:0] c_din_n;
  logic       c_wr_n, h_ack_n, f_done_n, f_busy_n, boot_busy_n;

  logic       host_go;
  logic [7:0] rate_eff;
  logic [7:0] vol_step;

  assign host_go  = h_req && (state != BOOT);
  assign rate_eff = (rate == 8'd0) ? 8'd1 : rate;
  // step never crosses the target, so 0/255 are never exceeded
  assign vol_step = (vol_sh < tgt) ? vol_sh + 8'd1 :
                    (vol_sh > tgt) ? vol_sh - 8'd1 : vol_sh;

  always_comb begin
    state_n     = state;
    boot_idx_n  = boot_idx;
    vol_n       = vol_sh;
    tgt_n       = tgt;
    rate_n      = rate;
    cnt_n       = cnt;
    pend_n      = pend;
    c_addr_n    = c_addr;
    c_din_n     = c_din;
    c_wr_n      = 1'b0;
    h_ack_n     = 1'b0;
    f_done_n    = 1'b0;
    f_busy_n    = f_busy;
    boot_busy_n = 1'b0;

    case (state)
`ifdef AUDIO_SEQ_BOOT_EN
      BOOT: begin
        boot_busy_n = 1'b1;
        c_wr_n      = 1'b1;
        c_addr_n    = boot_idx;
        c_din_n     = PRESET[boot_idx];
        boot_idx_n  = boot_idx + 4'd1;
        if (boot_idx == 4'd9) begin
          boot_idx_n = 4'd0;
          state_n    = IDLE;
        end
      end
`endif
      IDLE: begin
        if (f_start) begin
          if (f_target == vol_sh) begin
            f_done_n = 1'b1;
          end else begin
            tgt_n    = f_target;
            rate_n   = f_rate;
            cnt_n    = 8'd0;
            f_busy_n = 1'b1;
            state_n  = FADE_CNT;
          end
        end
      end
      FADE_CNT: begin
        if (clk_en) begin
          if (cnt == rate_eff - 8'd1) begin
            cnt_n   = 8'd0;
            vol_n   = vol_step;
            pend_n  = 1'b1;
            state_n = FADE_WR;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      FADE_WR: begin
        // pend clear means the step's write is on the port this cycle
        if (!pend) begin
          if (vol_sh == tgt) begin
            f_done_n = 1'b1;
            f_busy_n = 1'b0;
            state_n  = IDLE;
          end else begin
            state_n = FADE_CNT;
          end
        end
      end
      default: ;
    endcase

    // a pending fade step goes out on any cycle the host does not take
    if (state_n == FADE_WR && pend_n && !host_go) begin
      c_wr_n   = 1'b1;
      c_addr_n = 4'd6;
      c_din_n  = vol_n;
      pend_n   = 1'b0;
    end

    if (host_go) begin
      h_ack_n = 1'b1;
      if (h_addr <= 4'd9) begin
        c_wr_n   = 1'b1;
        c_addr_n = h_addr;
        c_din_n  = h_din;
      end
      // direct master-volume write overrides and silently cancels any fade
      if (h_addr == 4'd6) begin
        vol_n    = h_din;
        state_n  = IDLE;
        f_busy_n = 1'b0;
        f_done_n = 1'b0;
        pend_n   = 1'b0;
        cnt_n    = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RST_STATE;
      boot_idx  <= 4'd0;
      vol_sh    <= PRESET[6];
      tgt       <= 8'd0;
      rate      <= 8'd0;
      cnt       <= 8'd0;
      pend      <= 1'b0;
      c_addr    <= 4'd0;
      c_din     <= 8'd0;
      c_wr      <= 1'b0;
      h_ack     <= 1'b0;
      f_done    <= 1'b0;
      f_busy    <= 1'b0;
      boot_busy <= RST_BOOT;
    end else begin
      state     <= state_n;
      boot_idx  <= boot_idx_n;
      vol_sh    <= vol_n;
      tgt       <= tgt_n;
      rate      <= rate_n;
      cnt       <= cnt_n;
      pend      <= pend_n;
      c_addr    <= c_addr_n;
      c_din     <= c_din_n;
      c_wr      <= c_wr_n;
      h_ack     <= h_ack_n;
      f_done    <= f_done_n;
      f_busy    <= f_busy_n;
      boot_busy <= boot_busy_n;
    end
  end

endmodule

// File: tb/tb_audio_mixer_reg_sequencer.sv
// Directed bench for audio_mixer_reg_sequencer: boot, host writes, fades, collision, abort, reset.
module tb_audio_mixer_reg_sequencer;

`ifdef AUDIO_SEQ_BOOT_EN
  localparam logic BOOT_EXP = 1'b1;
`else
  localparam logic BOOT_EXP = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, clk_en = 1'b0, h_req = 1'b0, f_start = 1'b0;
  logic [3:0] h_addr = 4'd0;
  logic [7:0] h_din = 8'd0, f_target = 8'd0, f_rate = 8'd0;
  logic       h_ack, f_busy, f_done, c_wr, boot_busy;
  logic [3:0] c_addr;
  logic [7:0] c_din;

  audio_mixer_reg_sequencer dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .h_req(h_req), .h_addr(h_addr), .h_din(h_din), .h_ack(h_ack),
    .f_start(f_start), .f_target(f_target), .f_rate(f_rate),
    .f_busy(f_busy), .f_done(f_done),
    .c_addr(c_addr), .c_wr(c_wr), .c_din(c_din), .boot_busy(boot_busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [11:0] wlog[$];
  int          wcyc[$];
  int          fdone_cnt = 0, fdone_cyc = 0;
  bit          ce_auto = 1'b0;
  int          ce_ph = 0;
  logic [7:0]  pre [0:9] = '{8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd128, 8'd0, 8'd25, 8'd128};

  always @(posedge clk) cyc++;

  // write/done logger plus optional free-running clk_en (one pulse every 4 cycles)
  always @(negedge clk) begin
    if (rst && c_wr) begin
      wlog.push_back({c_addr, c_din});
      wcyc.push_back(cyc);
    end
    if (rst && f_done) begin
      fdone_cnt++;
      fdone_cyc = cyc;
    end
    if (ce_auto) begin
      ce_ph  = (ce_ph + 1) % 4;
      clk_en = (ce_ph == 0);
    end
  end

  task automatic clear_log();
    wlog.delete();
    wcyc.delete();
    fdone_cnt = 0;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d, output bit seen,
                            output int lat, output logic wr, output logic [3:0] ca,
                            output logic [7:0] cd);
    seen = 1'b0; lat = 0; wr = 1'b0; ca = 4'd0; cd = 8'd0;
    @(negedge clk);
    h_req = 1'b1; h_addr = a; h_din = d;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (h_ack) begin
        seen = 1'b1; wr = c_wr; ca = c_addr; cd = c_din;
      end
    end
    h_req = 1'b0;
  endtask

  task automatic start_fade(input logic [7:0] t, input logic [7:0] r);
    @(negedge clk);
    f_target = t; f_rate = r; f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget && fdone_cnt == 0; i++) @(negedge clk);
    checks++;
    if (fdone_cnt == 0) begin
      errors++;
      $display("FAIL %s: no f_done within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #10;
    checks++;
    if ({c_wr, h_ack, f_busy, f_done, c_addr, c_din} !== 16'd0 || boot_busy !== BOOT_EXP) begin
      errors++;
      $display("FAIL reset: wr=%b ack=%b busy=%b done=%b addr=%0d din=%0d boot_busy=%b, want zeros boot_busy=%b",
               c_wr, h_ack, f_busy, f_done, c_addr, c_din, boot_busy, BOOT_EXP);
    end
  endtask

  // called with rst low; releases it and checks the preset sequence
  task automatic test_boot();
    @(negedge clk);
    rst = 1'b1;
`ifdef AUDIO_SEQ_BOOT_EN
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (c_wr !== 1'b1 || c_addr !== 4'(i) || c_din !== pre[i] || boot_busy !== 1'b1) begin
        errors++;
        $display("FAIL boot[%0d]: wr=%b addr=%0d din=%0d busy=%b, want 1 %0d %0d 1",
                 i, c_wr, c_addr, c_din, boot_busy, i, pre[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (boot_busy !== 1'b0 || c_wr !== 1'b0) begin
      errors++;
      $display("FAIL boot_end: boot_busy=%b wr=%b, want 0 0", boot_busy, c_wr);
    end
`else
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (c_wr !== 1'b0 || boot_busy !== 1'b0) begin
        errors++;
        $display("FAIL noboot[%0d]: wr=%b boot_busy=%b, want 0 0", i, c_wr, boot_busy);
      end
    end
`endif
  endtask

  task automatic test_host_write();
    bit seen; int lat; logic wr; logic [3:0] ca; logic [7:0] cd;
    clear_log();
    host_write(4'd3, 8'h5A, seen, lat, wr, ca, cd);
    checks++;
    if (!seen || lat != 1 || wr !== 1'b1 || ca !== 4'd3 || cd !== 8'h5A) begin
      errors++;
      $display("FAIL host_wr: seen=%b lat=%0d wr=%b addr=%0d din=%h, want 1 1 1 3 5a", seen, lat, wr, ca, cd);
    end
    @(negedge clk);
    checks++;
    if (h_ack !== 1'b0 || c_wr !== 1'b0) begin
      errors++;
      $display("FAIL host_ack_len: ack=%b wr=%b, want 0 0", h_ack, c_wr);
    end
    clear_log();
    host_write(4'd12, 8'h77, seen, lat, wr, ca, cd);
    repeat (2) @(negedge clk);
    checks++;
    if (!seen || lat != 1 || wr !== 1'b0 || wlog.size() != 0) begin
      errors++;
      $display("FAIL host_badaddr: seen=%b lat=%0d wr=%b writes=%0d, want 1 1 0 0", seen, lat, wr, wlog.size());
    end
  endtask

  task automatic test_fade();
    clear_log();
    ce_auto = 1'b1;
    start_fade(8'd131, 8'd2);
    checks++;
    if (f_busy !== 1'b1) begin
      errors++;
      $display("FAIL fade_busy: f_busy=%b, want 1", f_busy);
    end
    wait_done(200, "fade_done");
    @(negedge clk);
    checks++;
    if (wlog.size() != 3) begin
      errors++;
      $display("FAIL fade_count: writes=%0d, want 3", wlog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wlog[i] !== {4'd6, 8'(129 + i)}) begin
          errors++;
          $display("FAIL fade_wr[%0d]: got %h, want %h", i, wlog[i], {4'd6, 8'(129 + i)});
        end
      end
      checks++;
      if (wcyc[1] - wcyc[0] != 8 || wcyc[2] - wcyc[1] != 8 || fdone_cyc != wcyc[2] + 1) begin
        errors++;
        $display("FAIL fade_timing: gaps %0d %0d done_off %0d, want 8 8 1",
                 wcyc[1] - wcyc[0], wcyc[2] - wcyc[1], fdone_cyc - wcyc[2]);
      end
    end
    checks++;
    if (f_busy !== 1'b0 || fdone_cnt != 1) begin
      errors++;
      $display("FAIL fade_end: f_busy=%b dones=%0d, want 0 1", f_busy, fdone_cnt);
    end
    ce_auto = 1'b0;
    clk_en = 1'b0;
  endtask

  task automatic test_same_target();
    clear_log();
    start_fade(8'd131, 8'd1);
    checks++;
    if (f_done !== 1'b1 || f_busy !== 1'b0 || c_wr !== 1'b0) begin
      errors++;
      $display("FAIL same_tgt: done=%b busy=%b wr=%b, want 1 0 0", f_done, f_busy, c_wr);
    end
    @(negedge clk);
    checks++;
    if (f_done !== 1'b0 || wlog.size() != 0) begin
      errors++;
      $display("FAIL same_tgt_pulse: done=%b writes=%0d, want 0 0", f_done, wlog.size());
    end
  endtask

  task automatic test_collision();
    clear_log();
    start_fade(8'd129, 8'd1);
    clk_en = 1'b1; h_req = 1'b1; h_addr = 4'd0; h_din = 8'h11;
    @(negedge clk);
    clk_en = 1'b0;
    checks++;
    if (h_ack !== 1'b1 || c_wr !== 1'b1 || c_addr !== 4'd0 || c_din !== 8'h11) begin
      errors++;
      $display("FAIL coll_host: ack=%b wr=%b addr=%0d din=%h, want 1 1 0 11", h_ack, c_wr, c_addr, c_din);
    end
    h_req = 1'b0;
    @(negedge clk);
    checks++;
    if (c_wr !== 1'b1 || c_addr !== 4'd6 || c_din !== 8'd130 || h_ack !== 1'b0) begin
      errors++;
      $display("FAIL coll_fade: wr=%b addr=%0d din=%0d ack=%b, want 1 6 130 0", c_wr, c_addr, c_din, h_ack);
    end
    for (int i = 0; i < 40 && fdone_cnt == 0; i++) begin
      @(negedge clk);
      clk_en = ~clk_en;
    end
    clk_en = 1'b0;
    checks++;
    if (wlog.size() != 3 || wlog[0] !== {4'd0, 8'h11} || wlog[1] !== {4'd6, 8'd130} ||
        wlog[2] !== {4'd6, 8'd129} || fdone_cnt != 1) begin
      errors++;
      $display("FAIL coll_seq: writes=%0d dones=%0d, want 3 writes (0:11,6:130,6:129) 1 done",
               wlog.size(), fdone_cnt);
    end
  endtask

  task automatic test_abort();
    bit seen; int lat; logic wr; logic [3:0] ca; logic [7:0] cd;
    clear_log();
    ce_auto = 1'b1;
    start_fade(8'd140, 8'd1);
    for (int i = 0; i < 100 && wlog.size() == 0; i++) @(negedge clk);
    host_write(4'd6, 8'd50, seen, lat, wr, ca, cd);
    @(negedge clk);
    checks++;
    if (!seen || f_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: ack=%b f_busy=%b, want 1 0", seen, f_busy);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (fdone_cnt != 0 || wlog.size() < 2 || wlog[wlog.size() - 1] !== {4'd6, 8'd50}) begin
      errors++;
      $display("FAIL abort_quiet: dones=%0d writes=%0d last=%h, want 0 >=2 632",
               fdone_cnt, wlog.size(), wlog.size() > 0 ? wlog[wlog.size() - 1] : 12'h0);
    end
    clear_log();
    start_fade(8'd51, 8'd1);
    wait_done(60, "abort_vol_done");
    checks++;
    if (wlog.size() != 1 || wlog[0] !== {4'd6, 8'd51}) begin
      errors++;
      $display("FAIL abort_vol: writes=%0d first=%h, want 1 633", wlog.size(),
               wlog.size() > 0 ? wlog[0] : 12'h0);
    end
    ce_auto = 1'b0;
    clk_en = 1'b0;
  endtask

  task automatic test_reset_mid_fade();
    clear_log();
    ce_auto = 1'b1;
    start_fade(8'd60, 8'd1);
    repeat (6) @(negedge clk);
    checks++;
    if (f_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: f_busy=%b, want 1", f_busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({c_wr, h_ack, f_busy, f_done, c_addr, c_din} !== 16'd0 || boot_busy !== BOOT_EXP) begin
      errors++;
      $display("FAIL rst_mid: wr=%b ack=%b busy=%b done=%b addr=%0d din=%0d boot_busy=%b, want zeros boot_busy=%b",
               c_wr, h_ack, f_busy, f_done, c_addr, c_din, boot_busy, BOOT_EXP);
    end
    ce_auto = 1'b0;
    clk_en = 1'b0;
    test_boot();
    clear_log();
    ce_auto = 1'b1;
    start_fade(8'd129, 8'd1);
    wait_done(60, "rst_vol_done");
    checks++;
    if (wlog.size() != 1 || wlog[0] !== {4'd6, 8'd129}) begin
      errors++;
      $display("FAIL rst_vol: writes=%0d first=%h, want 1 681", wlog.size(),
               wlog.size() > 0 ? wlog[0] : 12'h0);
    end
    ce_auto = 1'b0;
    clk_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_host_write();
    test_fade();
    test_same_target();
    test_collision();
    test_abort();
    test_reset_mid_fade();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
